// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 3x4 matrix keypad scanner.
// Key numbering is row-major: key = row*COLS + col.
package keypad_pkg;

  localparam int ROWS  = 3;
  localparam int COLS  = 4;
  localparam int NKEYS = ROWS * COLS;
  localparam int KEY_W = 4;
  localparam int DEB_W = 4;
  localparam int ROW_W = $clog2(ROWS);

  function automatic int key_idx(input int row, input int col);
    return row * COLS + col;
  endfunction

endpackage

// File: rtl/keypad_key_debounce.sv
// Per-key debouncer: counts consecutive samples that disagree with the held
// state and toggles the state once DEB_CNT of them arrive in a row.
module keypad_key_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic sample_i,
  output logic state_o,
  output logic rise_o
);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             prev_q;
  logic             rise_q, rise_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    cnt_d   = cnt_q;
    state_d = state_q;
    if (sample_en_i) begin
      if (sample_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_q >= DEB_W'(DEB_CNT - 1)) begin
        state_d = ~state_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
    rise_d = state_q & ~prev_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      prev_q  <= state_q;
      rise_q  <= rise_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad front end: drives one row low at a time, samples the synchronized
// columns at the end of each row dwell, debounces every key, and encodes the result.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 17,
  parameter int DEB_CNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  col_n,
  output logic [ROWS-1:0]  row_n,
  output logic [NKEYS-1:0] key_down,
  output logic [NKEYS-1:0] key_press,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid
);

  logic [SCAN_DIV-1:0] div_q, div_d;
  logic                tick;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROWS-1:0]     row_n_q, row_n_d;
  logic [COLS-1:0]     col_s1_q, col_s2_q;
  logic [COLS-1:0]     col_hit;
  logic [KEY_W-1:0]    code_q, code_d;
  logic                valid_q, valid_d;

  assign div_d = div_q + SCAN_DIV'(1);
  assign tick  = &div_q;

  // The row advances on the same edge that samples it, so each row settles a full dwell.
  always_comb begin
    row_d = row_q;
    if (tick) begin
      row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    end
    row_n_d = ~(ROWS'(1) << row_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      row_q    <= '0;
      row_n_q  <= ~ROWS'(1);
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      div_q    <= div_d;
      row_q    <= row_d;
      row_n_q  <= row_n_d;
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  assign row_n   = row_n_q;
  assign col_hit = ~col_s2_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = key_idx(r, c);
      keypad_key_debounce #(
        .DEB_CNT(DEB_CNT)
      ) u_deb (
        .clk        (clk),
        .rst        (rst),
        .sample_en_i(tick && (row_q == ROW_W'(r))),
        .sample_i   (col_hit[c]),
        .state_o    (key_down[K]),
        .rise_o     (key_press[K])
      );
    end
  end

  // Scan from the top down so the lowest held index is the last writer.
  always_comb begin
    code_d  = '0;
    valid_d = |key_down;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (key_down[k]) begin
        code_d = KEY_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a fast scan (SCAN_DIV=2, DEB_CNT=3):
// one frame = 12 clocks, a key toggles after three agreeing frame samples.
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic [2:0]  row_n;
  logic [11:0] key_down;
  logic [11:0] key_press;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [2:0][3:0] pressed;

  int checks = 0;
  int errors = 0;
  int cyc;
  int pulses[12];
  int first_cyc[12];
  logic [11:0] first_vec;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_DIV(2),
    .DEB_CNT (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_down (key_down),
    .key_press(key_press),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  // Passive keypad: a column reads low when a pressed key connects it to a driven row.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      col_n[c] = 1'b1;
      for (int r = 0; r < 3; r++) begin
        if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc       = 0;
    first_vec = '0;
    for (int k = 0; k < 12; k++) begin
      pulses[k]    = 0;
      first_cyc[k] = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (key_press != '0 && first_vec == '0) first_vec = key_press;
    for (int k = 0; k < 12; k++) begin
      if (key_press[k]) begin
        pulses[k]++;
        if (first_cyc[k] < 0) first_cyc[k] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int k = 0; k < 12; k++) s += pulses[k];
    return s;
  endfunction

  initial begin
    int seen;
    logic [2:0] prev_row;
    logic bounce[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst     = 1'b1;
    pressed = '0;
    clear_stats();
    @(negedge clk);

    // 1. Reset state and row rotation
    run(3);
    check("rst_row_n", 32'(row_n), 32'h6);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_key_press", 32'(key_press), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    rst = 1'b0;
    run(3);
    check("row0_dwell", 32'(row_n), 32'h6);
    run(1);
    check("row1", 32'(row_n), 32'h5);
    run(4);
    check("row2", 32'(row_n), 32'h3);
    run(4);
    check("row_wrap", 32'(row_n), 32'h6);

    // 2. Single key 5 held for 10 frames
    pressed[1][1] = 1'b1;
    clear_stats();
    run(120);
    check("k5_latency_ok", (first_cyc[5] > 0 && first_cyc[5] <= 40) ? 32'd1 : 32'd0, 32'd1);
    check("k5_pulses", pulses[5], 1);
    check("k5_only_pulse", total_pulses(), 1);
    check("k5_down", 32'(key_down), 32'h020);
    check("k5_code", 32'(key_code), 32'd5);
    check("k5_valid", 32'(key_valid), 32'd1);
    pressed = '0;
    clear_stats();
    run(72);
    check("k5_rel_down", 32'(key_down), 32'h0);
    check("k5_rel_no_pulse", total_pulses(), 0);
    check("k5_rel_valid", 32'(key_valid), 32'd0);

    // 3. Bounce never longer than two frames, then stable
    clear_stats();
    for (int f = 0; f < 8; f++) begin
      pressed[1][1] = bounce[f];
      run(12);
    end
    check("bounce_no_pulse", total_pulses(), 0);
    check("bounce_down", 32'(key_down), 32'h0);
    pressed[1][1] = 1'b1;
    clear_stats();
    run(60);
    check("bounce_stable_pulses", pulses[5], 1);
    check("bounce_stable_down", 32'(key_down), 32'h020);
    pressed = '0;
    run(72);

    // 4. Keys 4 and 6 together in the same row
    pressed[1][0] = 1'b1;
    pressed[1][2] = 1'b1;
    clear_stats();
    run(50);
    check("k46_press_vec", 32'(first_vec), 32'h050);
    check("k4_pulses", pulses[4], 1);
    check("k6_pulses", pulses[6], 1);
    check("k46_down", 32'(key_down), 32'h050);
    check("k46_code", 32'(key_code), 32'd4);
    pressed[1][0] = 1'b0;
    clear_stats();
    run(60);
    check("k6_down", 32'(key_down), 32'h040);
    check("k6_code", 32'(key_code), 32'd6);
    check("k4_rel_no_pulse", total_pulses(), 0);

    // 5. Reset while key 9 has two agreeing samples, key 6 still held
    for (int i = 0; i < 12 && row_n != 3'b110; i++) step();
    check("k9_align", 32'(row_n), 32'h6);
    pressed[2][1] = 1'b1;
    seen     = 0;
    prev_row = row_n;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      step();
      if (prev_row == 3'b011 && row_n == 3'b110) seen++;
      prev_row = row_n;
    end
    check("k9_two_samples", seen, 2);
    check("k9_not_yet_down", 32'(key_down), 32'h040);
    rst = 1'b1;
    step();
    check("mid_rst_row_n", 32'(row_n), 32'h6);
    check("mid_rst_down", 32'(key_down), 32'h0);
    check("mid_rst_press", 32'(key_press), 32'h0);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    rst = 1'b0;
    clear_stats();
    run(48);
    check("k6_after_rst_cyc", first_cyc[6], 33);
    check("k9_after_rst_cyc", first_cyc[9], 37);
    check("k9_after_rst_pulses", pulses[9], 1);
    check("k69_down", 32'(key_down), 32'h240);
    check("k69_code", 32'(key_code), 32'd6);
    pressed = '0;
    run(72);
    check("k69_rel_down", 32'(key_down), 32'h0);

    // 6. Long hold on key 0: one pulse, silent release
    pressed[0][0] = 1'b1;
    clear_stats();
    run(600);
    check("k0_hold_pulses", pulses[0], 1);
    check("k0_hold_total", total_pulses(), 1);
    check("k0_hold_down", 32'(key_down), 32'h001);
    check("k0_hold_code", 32'(key_code), 32'd0);
    check("k0_hold_valid", 32'(key_valid), 32'd1);
    pressed = '0;
    clear_stats();
    run(42);
    check("k0_rel_down", 32'(key_down), 32'h0);
    check("k0_rel_no_pulse", total_pulses(), 0);
    check("k0_rel_valid", 32'(key_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
